// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands in a FIFO, issues them one at a time
// to an external combinational ALU, and returns each result over a valid/ready stream.
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [2:0] cmd_sel,
    input  logic       cmd_acc,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_y,
    output logic       res_c,
    output logic [2:0] res_sel,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_y,
    input  logic       alu_c,
    output logic       busy,
    output logic [7:0] op_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic       acc;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    cmd_t             mem [DEPTH];
    cmd_t             wr_cmd;
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    state_t           state, state_d;
    logic [7:0]       acc, acc_d;
    logic [7:0]       alu_a_d, alu_b_d;
    logic [2:0]       alu_sel_d;
    logic             res_valid_d;
    logic [7:0]       res_y_d;
    logic             res_c_d;
    logic [2:0]       res_sel_d;
    logic [7:0]       op_count_d;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == CNT_W'(0));
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign wr_cmd    = '{a: cmd_a, b: cmd_b, sel: cmd_sel, acc: cmd_acc};
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || !empty;

    // FIFO storage; entries need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_cmd;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Next-state and datapath register updates for the issue FSM
    always_comb begin
        state_d     = state;
        pop         = 1'b0;
        acc_d       = acc;
        alu_a_d     = alu_a;
        alu_b_d     = alu_b;
        alu_sel_d   = alu_sel;
        res_valid_d = res_valid;
        res_y_d     = res_y;
        res_c_d     = res_c;
        res_sel_d   = res_sel;
        op_count_d  = op_count;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    alu_a_d   = head.acc ? acc : head.a;
                    alu_b_d   = head.b;
                    alu_sel_d = head.sel;
                    state_d   = DRIVE;
                end
            end
            DRIVE: begin
                res_y_d     = alu_y;
                res_c_d     = alu_c;
                res_sel_d   = alu_sel;
                acc_d       = alu_y;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_valid && res_ready) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count + 8'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_valid <= 1'b0;
            res_y     <= '0;
            res_c     <= 1'b0;
            res_sel   <= '0;
            op_count  <= '0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_sel   <= alu_sel_d;
            res_valid <= res_valid_d;
            res_y     <= res_y_d;
            res_c     <= res_c_d;
            res_sel   <= res_sel_d;
            op_count  <= op_count_d;
        end
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side initiator for the 8-bit combinational ALU (`alu_8bit`).
- Accepts ALU commands over a valid/ready stream and buffers them in a small FIFO.
- Issues them one at a time to an external ALU instance over registered operand/select lines.
- Captures the ALU result and carry, and returns them over a valid/ready result stream.
- An optional accumulator mode chains the previous result in as operand A.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept; high whenever the FIFO is not full.
- `cmd_a` in 8: operand A.
- `cmd_b` in 8: operand B.
- `cmd_sel` in 3: ALU op, same encoding as `alu_8bit`: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not-a, 110 shl, 111 shr.
- `cmd_acc` in 1: 1 = replace `cmd_a` with the accumulator at issue time.
- `res_valid` out 1: result held.
- `res_ready` in 1: consumer accepts the result.
- `res_y` out 8: captured result.
- `res_c` out 1: captured carry/borrow.
- `res_sel` out 3: echo of the issued op.
- `alu_a` out 8: registered drive to `alu_8bit.a`.
- `alu_b` out 8: registered drive to `alu_8bit.b`.
- `alu_sel` out 3: registered drive to `alu_8bit.sel`.
- `alu_y` in 8: from `alu_8bit.y`, combinational.
- `alu_c` in 1: from `alu_8bit.c`.
- `busy` out 1: state ≠ IDLE or FIFO not empty.
- `op_count` out 8: number of completed result handshakes; wraps 255→0.

## Operation
- Command FIFO:
  - Push on `cmd_valid && cmd_ready`; each entry stores {a, b, sel, acc}.
  - `cmd_ready` = !full, decoded from registered state only.
  - There is no bypass: a pushed command is visible to the FSM the cycle after the push.
- FSM states and transitions:
  - IDLE:
    - If the FIFO is not empty, pop the head and load `alu_a` with (acc ? accumulator : a), `alu_b` with b, `alu_sel` with sel.
    - Go to DRIVE.
  - DRIVE:
    - The ALU inputs are stable this whole cycle.
    - At the closing edge, capture `alu_y`/`alu_c`/`alu_sel` into `res_y`/`res_c`/`res_sel`, load accumulator ← `alu_y`, and set `res_valid`.
    - Go to HOLD.
  - HOLD:
    - `res_y`/`res_c`/`res_sel` stay stable while `res_valid` is high.
    - On `res_valid && res_ready`: clear `res_valid`, increment `op_count`, go to IDLE.
- Pop and push in the same cycle are legal. Count is unchanged, and the pointers each advance.
- Accumulator:
  - Updated only in DRIVE.
  - An `acc` command always sees the result of the immediately preceding issued command, because issue never starts before HOLD completes.
- Between commands, `alu_a`/`alu_b`/`alu_sel` keep their last driven values. The corresponding ALU output is not consumed.
- Width rules:
  - All data is 8 bits.
  - Carry semantics belong to the ALU; the sequencer only passes `alu_c` through to `res_c`.
  - FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. The occupancy count is log2(DEPTH)+1 bits.

## Timing
- Reset values:
  - Outputs: `cmd_ready`=1, `res_valid`=0, `res_y`=0, `res_c`=0, `res_sel`=0, `alu_a`=0, `alu_b`=0, `alu_sel`=0, `busy`=0, `op_count`=0.
  - Internal state: FIFO empty, accumulator 0, state IDLE.
- Latency:
  - Conditions: FIFO empty, FSM in IDLE, command pushed at edge N.
  - Edge N+1: the FSM sees the entry, pops it, and `alu_*` is driven.
  - Edge N+2: `res_valid` goes high.
- Throughput: with `res_ready` held high, one result every 3 cycles (IDLE→DRIVE→HOLD).
- Backpressure capacity: with `res_ready` held low, DEPTH+1 commands are accepted before `cmd_ready` drops (one in HOLD, DEPTH in the FIFO).
- Reset mid-operation:
  - Takes effect at the next edge regardless of state.
  - Discards the pending result and all FIFO entries.
  - A command presented in the same cycle as `rst` is not accepted.
- `op_count` at 255 increments to 0 on the next completed handshake. No flag is raised.

## Test plan
- Basic add/sub:
  - Push {0x0F, 0x01, 000} → `res_y`=0x10, `res_c`=0, `res_valid` high exactly 2 edges after the push.
  - Push {0xFF, 0x01, 000} → `res_y`=0x00, `res_c`=1.
  - Push {0x01, 0x02, 001} → `res_y`=0xFF, `res_c`=1.
- Logic ops in order:
  - Push and (0xF0, 0x0F), then xor (0xCC, 0x33), then shl (0x0F), then shr (0xF0).
  - Required results in order: 0x00, 0xFF, 0x1E, 0x78, each with `res_c`=0 and `res_sel` echoed.
- Accumulator chain:
  - Push add {0x05, 0x03} → 0x08.
  - Then push add with `cmd_acc`=1, b=0x02, `cmd_a`=0xAA (ignored) → 0x0A.
  - Then push not with `cmd_acc`=1 → 0xF5.
- Backpressure:
  - Hold `res_ready`=0 and push continuously → exactly 5 commands accepted, then `cmd_ready`=0.
  - Release `res_ready` → all 5 results in order with no loss.
  - `op_count`=5 and `busy`=0 at the end.
- Reset mid-op:
  - Assert `rst` for one cycle while in HOLD with 3 commands queued.
  - Required: `res_valid`=0, `busy`=0, `op_count`=0 and `cmd_ready`=1 the cycle after reset.
  - A following `cmd_acc` add with b=0x01 returns 0x01 (accumulator cleared).
- Counter wrap: complete 256 commands → `op_count` returns to 0x00.
